ex_mdu: RTL
===========

Name: ex_mdu

Overview:
Parametrised execute stage for the 5-stage MIPS pipeline. It sits between id_ex and ex_mem, and replaces the purely combinational logic/shift EX.
- Adds add/sub/compare, signed/unsigned multiply, an iterative signed/unsigned divider, and block-owned HI/LO registers.
- Requests a pipeline stall while a divide is in flight.
- Adds correct arithmetic right shift and signed-overflow detection.

Parameters:
DATA_W, 32, operand/result width; power of two, ≥8
REG_ADDR_W, 5, register-file address width
SHAMT_W, $clog2(DATA_W), shift-amount bits taken from reg1_i

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
aluop_i  in  8  operation code (package constants)
alusel_i  in  3  result-class select (LOGIC, SHIFT, ARITH, MOVE)
reg1_i  in  DATA_W  operand 1 / shift amount
reg2_i  in  DATA_W  operand 2 / shifted value
wd_i  in  REG_ADDR_W  destination register
wreg_i  in  1  destination write enable
flush_i  in  1  pipeline flush; aborts divide, suppresses HI/LO write
wd_o  out  REG_ADDR_W  = wd_i
wreg_o  out  1  wreg_i, forced 0 on signed overflow
wdata_o  out  DATA_W  selected result
ov_o  out  1  signed overflow on ADD/SUB (combinational)
stallreq_o  out  1  hold IF/ID/EX; divide in progress

Behaviour:
- Reset (async, rst=1):
  - HI=LO=0; divider FSM=IDLE; counter=0.
  - Combinational outputs driven: wd_o=0, wreg_o=0, wdata_o=0, ov_o=0, stallreq_o=0.
- Non-divide ops are combinational, zero latency.
- LOGIC: OR, AND, NOR, XOR.
- SHIFT: SLL, SRL, SRA; amount = reg1_i[SHAMT_W-1:0]. SRA sign-fills; amount 0 returns reg2_i unchanged.
- ARITH:
  - ADD/ADDU/SUB/SUBU are modulo 2^DATA_W.
  - SLT is signed compare, SLTU unsigned; result is 1 or 0.
  - ADD/SUB signed overflow -> ov_o=1, wreg_o=0.
- MOVE: MFHI/MFLO return the HI/LO register value.
- MTHI/MTLO write reg1_i into HI/LO at the clock edge. Writes are idempotent if the pipeline holds the op.
- MULT/MULTU: 2*DATA_W product computed combinationally; {HI,LO} <= product at the clock edge.
- Unknown aluop or alusel: wdata_o=0, no HI/LO change.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE: on DIV/DIVU (and no flush_i), latch operand magnitudes and sign flags; stallreq_o=1 in this same cycle.
    - Divisor 0 -> DONE.
    - Otherwise -> BUSY with counter=0.
  - BUSY: one restoring-division bit per cycle; stallreq_o=1; counter increments. When counter==DATA_W-1 -> DONE.
  - DONE: stallreq_o=0. At the edge ending DONE: {HI,LO} <= {remainder, quotient}, then -> IDLE. The pipeline advances on that same edge.
- Divide latency: stall held for DATA_W+1 cycles (DATA_W=32: 33). Result is visible to the next instruction's MFHI/MFLO.
- Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient = all-ones, remainder = dividend; no trap. Latency is 1 stall cycle.
- Most-negative / -1 (signed): quotient = most-negative, remainder = 0. No overflow flag.
- flush_i in any state:
  - FSM -> IDLE at the next edge; stallreq_o=0 combinationally.
  - No HI/LO write from any op in that cycle.
- A DIV op still present in IDLE after DONE is not restarted. A "done-ack" flag is set in DONE and cleared when aluop_i is not DIV/DIVU or on flush.
- Asynchronous reset mid-divide: immediately IDLE, partial result discarded.

Decomposition:
- Shared package (extends existing defines):
  - all EXE_*_OP codes, including ADD/ADDU/SUB/SUBU/SLT/SLTU/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO;
  - EXE_RES_* select codes;
  - divider state encoding.
- Sub-module div_iter: the iterative divider with start/abort/signed inputs and done/quotient/remainder outputs. All other logic stays in ex_mdu.

Test Plan:
- Logic and shift, no stalls:
  - OR 0xF0F0_0000 | 0x0000_0F0F -> 0xF0F0_0F0F.
  - SRA reg2=0x8000_0000, amount=4 -> 0xF800_0000.
  - SRL with the same inputs -> 0x0800_0000.
  - stallreq_o stays 0 throughout.
- ADD overflow: 0x7FFF_FFFF + 1 -> ov_o=1, wreg_o=0. ADDU with the same operands -> 0x8000_0000, ov_o=0, wreg_o=wreg_i.
- MULT then MFHI/MFLO:
  - MULT -3 × 5 -> next cycle MFHI=0xFFFF_FFFF, MFLO=0xFFFF_FFF1.
  - MULTU 0xFFFF_FFFF × 2 -> HI=1, LO=0xFFFF_FFFE.
- DIV -7/2 held stable:
  - stallreq_o high exactly 33 cycles.
  - Then MFLO=0xFFFF_FFFD (-3), MFHI=0xFFFF_FFFF (-1).
  - DIVU 7/2 -> LO=3, HI=1.
- Divide by zero: DIVU 100/0 -> 1 stall cycle; LO=0xFFFF_FFFF, HI=100.
- Abort paths:
  - flush_i asserted at BUSY cycle 10 -> stallreq_o drops that cycle, HI/LO unchanged.
  - rst pulse mid-divide -> outputs 0, HI=LO=0.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_pkg
// Purpose  : Operation codes, result-class selects and divider state encoding
//            shared by the execute stage and its iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package ex_mdu_pkg;

    // ALU operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

    // Result-class selects
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    // Divider state encoding
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // True for either divide flavour
    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    // True for a select code the stage understands; anything else is inert
    function automatic logic is_valid_sel(input logic [2:0] sel);
        return (sel == EXE_RES_NOP)   || (sel == EXE_RES_LOGIC) ||
               (sel == EXE_RES_SHIFT) || (sel == EXE_RES_MOVE)  ||
               (sel == EXE_RES_ARITH);
    endfunction

endpackage : ex_mdu_pkg
`default_nettype wire

// File: rtl/ex_mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu_div_iter
// Purpose  : Iterative restoring divider, one quotient bit per cycle, with
//            signed fix-up, divide-by-zero shortcut and abort.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mdu_div_iter
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam int              MSB      = DATA_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder magnitude
    logic [DATA_W-1:0] quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;

    assign w_dvd_neg = signed_i & dividend_i[MSB];
    assign w_dvs_neg = signed_i & divisor_i[MSB];
    assign w_dvd_mag = w_dvd_neg ? -dividend_i : dividend_i;
    assign w_dvs_mag = w_dvs_neg ? -divisor_i  : divisor_i;

    // Trial subtraction: bring down the next dividend bit and subtract divisor
    assign w_shift = {rem_q, quo_q[MSB]};
    assign w_diff  = w_shift - {1'b0, dvs_q};

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i && !abort_i) begin
                    cnt_d = '0;
                    dvs_d = w_dvs_mag;
                    if (divisor_i == '0) begin
                        // No trap: quotient all-ones, remainder is the raw dividend
                        quo_d     = '1;
                        rem_d     = dividend_i;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DIV_DONE;
                    end else begin
                        quo_d     = w_dvd_mag;
                        rem_d     = '0;
                        neg_quo_d = w_dvd_neg ^ w_dvs_neg;
                        neg_rem_d = w_dvd_neg;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (abort_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    if (!w_diff[DATA_W]) begin
                        rem_d = w_diff[MSB:0];
                        quo_d = {quo_q[MSB-1:0], 1'b1};
                    end else begin
                        rem_d = w_shift[MSB:0];
                        quo_d = {quo_q[MSB-1:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // Divider state and datapath registers; reset discards any partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
    assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule : ex_mdu_div_iter
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// Module   : ex_mdu
// Purpose  : Pipeline execute stage: logic, shift, add/sub/compare, multiply,
//            iterative divide and block-owned HI/LO registers, with a stall
//            request while a divide is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SHAMT_W    = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  ov_o,
    output logic                  stallreq_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                ack_q, ack_d;    // divide already retired for this op

    logic                w_sel_ok;
    logic                w_div_op;
    logic                w_div_start;
    logic                w_div_busy;
    logic                w_div_done;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    logic [SHAMT_W-1:0]  w_shamt;
    logic signed [DATA_W-1:0] w_sra;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic                w_ov_add;
    logic                w_ov_sub;
    logic                w_slt;
    logic                w_sltu;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;

    logic [DATA_W-1:0]   w_result;
    logic                w_ov;
    logic                w_stall;

    assign w_sel_ok    = is_valid_sel(alusel_i);
    assign w_div_op    = w_sel_ok & is_div_op(aluop_i);
    assign w_div_start = w_div_op & ~flush_i & ~ack_q;

    assign w_shamt  = reg1_i[SHAMT_W-1:0];
    assign w_sra    = $signed(reg2_i) >>> w_shamt;
    assign w_sum    = reg1_i + reg2_i;
    assign w_diff   = reg1_i - reg2_i;
    // Overflow when like-signed operands yield an opposite-signed result
    assign w_ov_add = (reg1_i[MSB] == reg2_i[MSB]) && (w_sum[MSB]  != reg1_i[MSB]);
    assign w_ov_sub = (reg1_i[MSB] != reg2_i[MSB]) && (w_diff[MSB] != reg1_i[MSB]);
    assign w_slt    = $signed(reg1_i) < $signed(reg2_i);
    assign w_sltu   = reg1_i < reg2_i;
    // Full-width products; sign-extending first gives a correct signed product
    assign w_prod_s = {{DATA_W{reg1_i[MSB]}}, reg1_i} * {{DATA_W{reg2_i[MSB]}}, reg2_i};
    assign w_prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    ex_mdu_div_iter #(
        .DATA_W (DATA_W)
    ) u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_div_start),
        .abort_i     (flush_i),
        .signed_i    (aluop_i == EXE_DIV_OP),
        .dividend_i  (reg1_i),
        .divisor_i   (reg2_i),
        .busy_o      (w_div_busy),
        .done_o      (w_div_done),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    // Result selection by class and operation; unknown codes give zero
    always_comb begin
        w_result = '0;
        w_ov     = 1'b0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  w_result = reg1_i | reg2_i;
                    EXE_AND_OP: w_result = reg1_i & reg2_i;
                    EXE_NOR_OP: w_result = ~(reg1_i | reg2_i);
                    EXE_XOR_OP: w_result = reg1_i ^ reg2_i;
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: w_result = reg2_i << w_shamt;
                    EXE_SRL_OP: w_result = reg2_i >> w_shamt;
                    EXE_SRA_OP: w_result = w_sra;
                    default:    w_result = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP: begin
                        w_result = w_sum;
                        w_ov     = w_ov_add;
                    end
                    EXE_ADDU_OP: w_result = w_sum;
                    EXE_SUB_OP: begin
                        w_result = w_diff;
                        w_ov     = w_ov_sub;
                    end
                    EXE_SUBU_OP: w_result = w_diff;
                    EXE_SLT_OP:  w_result = {{(DATA_W-1){1'b0}}, w_slt};
                    EXE_SLTU_OP: w_result = {{(DATA_W-1){1'b0}}, w_sltu};
                    default:     w_result = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP: w_result = hi_q;
                    EXE_MFLO_OP: w_result = lo_q;
                    default:     w_result = '0;
                endcase
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    // HI/LO next value: divide retirement first, then multiply and moves
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!flush_i) begin
            if (w_div_done) begin
                hi_d = w_rem;
                lo_d = w_quo;
            end else if (w_sel_ok) begin
                case (aluop_i)
                    EXE_MULT_OP:  {hi_d, lo_d} = w_prod_s;
                    EXE_MULTU_OP: {hi_d, lo_d} = w_prod_u;
                    EXE_MTHI_OP:  hi_d = reg1_i;
                    EXE_MTLO_OP:  lo_d = reg1_i;
                    default: begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                endcase
            end
        end
    end

    // Done-ack keeps a held divide op from restarting once it has retired
    always_comb begin
        ack_d = ack_q;
        if (flush_i) begin
            ack_d = 1'b0;
        end else if (w_div_done) begin
            ack_d = 1'b1;
        end else if (!w_div_op) begin
            ack_d = 1'b0;
        end
    end

    // HI/LO and done-ack registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            ack_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            ack_q <= ack_d;
        end
    end

    // Stall through the launch cycle and every iteration; DONE lets the pipe go
    assign w_stall = ~flush_i & (w_div_busy | (w_div_start & ~w_div_done));

    assign wd_o       = rst ? '0   : wd_i;
    assign wreg_o     = rst ? 1'b0 : (wreg_i & ~w_ov);
    assign wdata_o    = rst ? '0   : w_result;
    assign ov_o       = rst ? 1'b0 : w_ov;
    assign stallreq_o = rst ? 1'b0 : w_stall;

endmodule : ex_mdu
`default_nettype wire
